// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } seq_state_t;

  // Width able to hold 0..v-1, never narrower than one bit.
  function automatic int cnt_width(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Reset-free flop chain for bringing one asynchronous bit into the local clock domain.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL supervisor: pulses the PLL reset, qualifies lock, retries on timeout and
// releases downstream reset domains one after another once lock is stable.
//
// state     | meaning
// PLL_RST   | PLL held in reset for PLL_RST_CYCLES, all domains in reset
// WAIT_LOCK | PLL running, waiting for LOCK_STABLE_CYCLES of continuous lock
// RELEASE   | domains released every STAGGER_CYCLES, bit 0 first
// RUN       | all domains out of reset, ready asserted
// FAULT     | retries exhausted, waiting for clear_fault
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int N_DOMAINS           = 4,
  parameter int PLL_RST_CYCLES      = 25,
  parameter int LOCK_STABLE_CYCLES  = 250,
  parameter int LOCK_TIMEOUT_CYCLES = 25000,
  parameter int STAGGER_CYCLES      = 16,
  parameter int MAX_RETRIES         = 7,
  parameter int SYNC_STAGES         = 2
) (
  input  logic                 clkin,
  input  logic                 reset,
  input  logic                 pll_lock,
  input  logic                 clear_fault,
  output logic                 pll_reset,
  output logic [N_DOMAINS-1:0] domain_rst,
  output logic                 ready,
  output logic                 fault,
  output logic [3:0]           retry_count,
  output logic [7:0]           lock_loss_count
);

  localparam int RELEASE_CYCLES = N_DOMAINS * STAGGER_CYCLES;
  localparam int TIMER_MAX =
    (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES)
      ? ((PLL_RST_CYCLES > RELEASE_CYCLES) ? PLL_RST_CYCLES : RELEASE_CYCLES)
      : ((LOCK_TIMEOUT_CYCLES > RELEASE_CYCLES) ? LOCK_TIMEOUT_CYCLES : RELEASE_CYCLES);
  localparam int TW = cnt_width(TIMER_MAX);
  localparam int SW = cnt_width(LOCK_STABLE_CYCLES);

  seq_state_t state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [SW-1:0] stable, stable_nxt;
  logic [N_DOMAINS-1:0] domain_rst_nxt;
  logic [3:0] retry_nxt;
  logic [7:0] loss_nxt;
  logic lock_s;
  logic lock_lost;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (clkin),
    .d   (pll_lock),
    .q   (lock_s)
  );

  always_comb begin
    state_nxt      = state;
    timer_nxt      = timer + 1'b1;
    stable_nxt     = '0;
    domain_rst_nxt = '1;
    retry_nxt      = retry_count;
    loss_nxt       = lock_loss_count;
    lock_lost      = 1'b0;
    case (state)
      PLL_RST: begin
        if (timer == TW'(PLL_RST_CYCLES - 1)) begin
          state_nxt = WAIT_LOCK;
          timer_nxt = '0;
        end
      end
      WAIT_LOCK: begin
        // Qualification is checked first so it wins a tie with the timeout.
        if (lock_s && stable == SW'(LOCK_STABLE_CYCLES - 1)) begin
          state_nxt = RELEASE;
          timer_nxt = '0;
          retry_nxt = '0;
        end else if (timer == TW'(LOCK_TIMEOUT_CYCLES - 1)) begin
          retry_nxt = retry_count + 4'd1;
          timer_nxt = '0;
          state_nxt = (retry_nxt == 4'(MAX_RETRIES)) ? FAULT : PLL_RST;
        end else begin
          stable_nxt = lock_s ? stable + 1'b1 : '0;
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          lock_lost = 1'b1;
        end else begin
          domain_rst_nxt = domain_rst;
          for (int i = 0; i < N_DOMAINS; i++) begin
            if (timer == TW'((i + 1) * STAGGER_CYCLES - 1)) domain_rst_nxt[i] = 1'b0;
          end
          if (timer == TW'(RELEASE_CYCLES - 1)) begin
            state_nxt = RUN;
            timer_nxt = '0;
          end
        end
      end
      RUN: begin
        timer_nxt = '0;
        if (!lock_s) lock_lost = 1'b1;
        else domain_rst_nxt = '0;
      end
      FAULT: begin
        timer_nxt = '0;
        if (clear_fault) begin
          state_nxt = PLL_RST;
          retry_nxt = '0;
        end
      end
      default: begin
        state_nxt = PLL_RST;
        timer_nxt = '0;
      end
    endcase
    if (lock_lost) begin
      state_nxt = PLL_RST;
      timer_nxt = '0;
      if (lock_loss_count != 8'hFF) loss_nxt = lock_loss_count + 8'd1;
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state           <= PLL_RST;
      timer           <= '0;
      stable          <= '0;
      pll_reset       <= 1'b1;
      domain_rst      <= '1;
      ready           <= 1'b0;
      fault           <= 1'b0;
      retry_count     <= '0;
      lock_loss_count <= '0;
    end else begin
      state           <= state_nxt;
      timer           <= timer_nxt;
      stable          <= stable_nxt;
      pll_reset       <= (state_nxt == PLL_RST) || (state_nxt == FAULT);
      domain_rst      <= domain_rst_nxt;
      ready           <= (state_nxt == RUN);
      fault           <= (state_nxt == FAULT);
      retry_count     <= retry_nxt;
      lock_loss_count <= loss_nxt;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with a hand-derived cycle timeline.
module tb_pll_reset_sequencer;

  logic       clkin = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       clear_fault;
  logic       pll_reset;
  logic [2:0] domain_rst;
  logic       ready;
  logic       fault;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_count;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clkin = ~clkin;

  pll_reset_sequencer #(
    .N_DOMAINS           (3),
    .PLL_RST_CYCLES      (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (64),
    .STAGGER_CYCLES      (3),
    .MAX_RETRIES         (2),
    .SYNC_STAGES         (2)
  ) dut (
    .clkin           (clkin),
    .reset           (reset),
    .pll_lock        (pll_lock),
    .clear_fault     (clear_fault),
    .pll_reset       (pll_reset),
    .domain_rst      (domain_rst),
    .ready           (ready),
    .fault           (fault),
    .retry_count     (retry_count),
    .lock_loss_count (lock_loss_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  task automatic step();
    @(posedge clkin);
    #1;
    cyc++;
  endtask

  task automatic goto(input int target);
    while (cyc < target) step();
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_pll_reset"}, pll_reset, 1);
    check_eq({tag, "_domain_rst"}, domain_rst, 3'b111);
    check_eq({tag, "_ready"}, ready, 0);
    check_eq({tag, "_fault"}, fault, 0);
    check_eq({tag, "_retry"}, retry_count, 0);
    check_eq({tag, "_loss"}, lock_loss_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset       = 1'b1;
    pll_lock    = 1'b1;
    clear_fault = 1'b0;
    repeat (4) step();
    check_reset_values("rst");
    reset = 1'b0;
    cyc   = 0;

    // Clean bring-up with lock present throughout.
    goto(3);  check_eq("t1_pllrst_c3", pll_reset, 1);
    goto(4);  check_eq("t1_pllrst_c4", pll_reset, 0);
    goto(14); check_eq("t1_dom_c14", domain_rst, 3'b111);
    goto(15); check_eq("t1_dom_c15", domain_rst, 3'b110);
    goto(17); check_eq("t1_dom_c17", domain_rst, 3'b110);
    goto(18); check_eq("t1_dom_c18", domain_rst, 3'b100);
    goto(20); check_eq("t1_ready_c20", ready, 0);
    goto(21);
    check_eq("t1_dom_c21", domain_rst, 3'b000);
    check_eq("t1_ready_c21", ready, 1);
    check_eq("t1_retry", retry_count, 0);

    // One-cycle lock drop in RUN.
    pll_lock = 1'b0; step(); pll_lock = 1'b1;
    goto(23);
    check_eq("t4_ready_c23", ready, 1);
    check_eq("t4_dom_c23", domain_rst, 3'b000);
    goto(24);
    check_eq("t4_dom_c24", domain_rst, 3'b111);
    check_eq("t4_ready_c24", ready, 0);
    check_eq("t4_loss", lock_loss_count, 1);
    check_eq("t4_pllrst_c24", pll_reset, 1);
    check_eq("t4_retry", retry_count, 0);
    goto(27); check_eq("t4_pllrst_c27", pll_reset, 1);
    goto(28); check_eq("t4_pllrst_c28", pll_reset, 0);

    // Lock drop in RELEASE just after bit 0 is released.
    goto(38); check_eq("t5_dom_c38", domain_rst, 3'b111);
    goto(39); check_eq("t5_dom_c39", domain_rst, 3'b110);
    pll_lock = 1'b0; step(); pll_lock = 1'b1;
    goto(41); check_eq("t5_dom_c41", domain_rst, 3'b110);
    goto(42);
    check_eq("t5_dom_c42", domain_rst, 3'b111);
    check_eq("t5_loss", lock_loss_count, 2);
    check_eq("t5_pllrst_c42", pll_reset, 1);

    // Lock glitch during qualification restarts the stable count.
    pll_lock = 1'b0;
    goto(48); pll_lock = 1'b1;
    goto(55); pll_lock = 1'b0; step(); pll_lock = 1'b1;
    goto(61); check_eq("t3_dom_c61", domain_rst, 3'b111);
    goto(68); check_eq("t3_dom_c68", domain_rst, 3'b111);
    goto(69); check_eq("t3_dom_c69", domain_rst, 3'b110);
    goto(74); check_eq("t3_ready_c74", ready, 0);
    goto(75);
    check_eq("t3_ready_c75", ready, 1);
    check_eq("t3_dom_c75", domain_rst, 3'b000);

    // Lock held low: two timeouts into FAULT, then clear.
    pll_lock = 1'b0;
    goto(77); check_eq("t2_ready_c77", ready, 1);
    goto(78);
    check_eq("t2_ready_c78", ready, 0);
    check_eq("t2_loss", lock_loss_count, 3);
    goto(145);
    check_eq("t2_pllrst_c145", pll_reset, 0);
    check_eq("t2_retry_c145", retry_count, 0);
    goto(146);
    check_eq("t2_pllrst_c146", pll_reset, 1);
    check_eq("t2_retry_c146", retry_count, 1);
    goto(149); check_eq("t2_pllrst_c149", pll_reset, 1);
    goto(150); check_eq("t2_pllrst_c150", pll_reset, 0);
    goto(160); clear_fault = 1'b1; step(); clear_fault = 1'b0;
    goto(162);
    check_eq("t2_ignclr_retry", retry_count, 1);
    check_eq("t2_ignclr_pllrst", pll_reset, 0);
    goto(213);
    check_eq("t2_fault_c213", fault, 0);
    check_eq("t2_retry_c213", retry_count, 1);
    goto(214);
    check_eq("t2_fault_c214", fault, 1);
    check_eq("t2_retry_c214", retry_count, 2);
    check_eq("t2_pllrst_c214", pll_reset, 1);
    check_eq("t2_dom_c214", domain_rst, 3'b111);
    goto(220); check_eq("t2_fault_c220", fault, 1);
    clear_fault = 1'b1; pll_lock = 1'b1; step(); clear_fault = 1'b0;
    check_eq("t2_clr_fault", fault, 0);
    check_eq("t2_clr_retry", retry_count, 0);
    check_eq("t2_clr_pllrst", pll_reset, 1);
    goto(224); check_eq("t2_pllrst_c224", pll_reset, 1);
    goto(225); check_eq("t2_pllrst_c225", pll_reset, 0);

    // Reset in the middle of RELEASE.
    goto(235); check_eq("t6_dom_c235", domain_rst, 3'b111);
    goto(236);
    check_eq("t6_dom_c236", domain_rst, 3'b110);
    check_eq("t6_loss_pre", lock_loss_count, 3);
    reset = 1'b1; step(); reset = 1'b0;
    check_reset_values("t6_midrel");

    // Repeated lock losses in RELEASE until the counter saturates.
    for (int k = 1; k <= 300; k++) begin
      n = 0;
      while (domain_rst[0] !== 1'b0 && n < 60) begin step(); n++; end
      if (n == 60) begin
        check_eq("t6_wait_release", domain_rst[0], 0);
        break;
      end
      pll_lock = 1'b0; step(); pll_lock = 1'b1;
      n = 0;
      while (domain_rst !== 3'b111 && n < 10) begin step(); n++; end
      if (n == 10) begin
        check_eq("t6_wait_reassert", domain_rst, 3'b111);
        break;
      end
      if (k == 1 || k == 254 || k == 255 || k == 256 || k == 300)
        check_eq($sformatf("t6_loss_k%0d", k), lock_loss_count, (k > 255) ? 255 : k);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
